// File: rtl/count_display_driver.sv
// Two-digit multiplexed 7-segment driver. It converts a sampled binary count to BCD
// once per scan frame, then shows the result on a units digit and a tens digit.
`timescale 1ns/1ps
module count_display_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_LZ    = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [7:0] VAL,
    output logic [6:0] SEG,
    output logic [1:0] DIG,
    output logic       BUSY,
    output logic [1:0] state_dbg
);
    localparam int CW = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    state_t        state;
    logic [CW-1:0] pre_cnt;
    logic          tick;
    logic          sel;
    logic [2:0]    iter;
    logic [7:0]    bin;
    logic [7:0]    bcd;
    logic          oor;
    logic [3:0]    tens;
    logic [3:0]    units;
    logic          door;
    logic [7:0]    bcd_adj;
    logic [15:0]   shifted;
    logic [6:0]    seg_next;

    assign tick      = (pre_cnt == CW'(REFRESH_DIV - 1));
    assign state_dbg = state;

    function automatic logic [6:0] digit_code(input logic [3:0] d);
        case (d)
            4'd0:    digit_code = 7'h40;
            4'd1:    digit_code = 7'h79;
            4'd2:    digit_code = 7'h24;
            4'd3:    digit_code = 7'h30;
            4'd4:    digit_code = 7'h19;
            4'd5:    digit_code = 7'h12;
            4'd6:    digit_code = 7'h02;
            4'd7:    digit_code = 7'h78;
            4'd8:    digit_code = 7'h00;
            4'd9:    digit_code = 7'h10;
            default: digit_code = 7'h7F;
        endcase
    endfunction

    // Only the tens and units nibbles are kept: the hundreds carry is shifted out,
    // which leaves the lower digits intact; out-of-range values are flagged by oor.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 2; i++) begin
            if (bcd[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
        end
        shifted = {bcd_adj, bin} << 1;
    end

    always_comb begin
        if (door)                              seg_next = 7'h3F;
        else if (!sel)                         seg_next = digit_code(units);
        else if (BLANK_LZ != 0 && tens == '0)  seg_next = 7'h7F;
        else                                   seg_next = digit_code(tens);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pre_cnt <= '0;
            sel     <= 1'b0;
            state   <= IDLE;
            iter    <= '0;
            bin     <= '0;
            bcd     <= '0;
            oor     <= 1'b0;
            tens    <= '0;
            units   <= '0;
            door    <= 1'b0;
            BUSY    <= 1'b0;
            SEG     <= 7'h40;
            DIG     <= 2'b10;
        end else begin
            pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
            if (tick) sel <= ~sel;
            DIG <= sel ? 2'b01 : 2'b10;
            SEG <= seg_next;
            case (state)
                IDLE: begin
                    // Frame start: the tick that returns the scan to the units slot.
                    if (tick && sel) begin
                        state <= CONV;
                        bin   <= VAL;
                        bcd   <= '0;
                        oor   <= (VAL > 8'd99);
                        iter  <= '0;
                        BUSY  <= 1'b1;
                    end
                end
                CONV: begin
                    bcd  <= shifted[15:8];
                    bin  <= shifted[7:0];
                    iter <= iter + 1'b1;
                    if (iter == 3'd7) state <= LOAD;
                end
                LOAD: begin
                    tens  <= bcd[7:4];
                    units <= bcd[3:0];
                    door  <= oor;
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    BUSY  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_count_display_driver.sv
// Bench for count_display_driver: two instances (leading-zero blanking on and off)
// compared every cycle against a frame-level behavioural model.
`timescale 1ns/1ps
module tb_count_display_driver;
    localparam int RD    = 16;
    localparam int FRAME = 2 * RD;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [7:0] VAL = 8'd0;
    logic [6:0] seg, seg_nb;
    logic [1:0] dig, dig_nb;
    logic       busy, busy_nb;
    logic [1:0] st, st_nb;

    int checks = 0;
    int passes = 0;

    // Model state: n = clock edges since reset release, disp = value on the display.
    logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    int   n = 0, disp = 0, sample = 0, load_at = 0;
    bit   pend = 1'b0;
    bit   sel_m;
    logic [6:0] exp_seg = 7'h40, exp_seg_nb = 7'h40;
    logic [1:0] exp_dig = 2'b10;
    logic       exp_busy = 1'b0;

    count_display_driver #(.REFRESH_DIV(RD), .BLANK_LZ(1)) dut (
        .CLK(CLK), .RST(RST), .VAL(VAL), .SEG(seg), .DIG(dig), .BUSY(busy), .state_dbg(st)
    );
    count_display_driver #(.REFRESH_DIV(RD), .BLANK_LZ(0)) dut_nb (
        .CLK(CLK), .RST(RST), .VAL(VAL), .SEG(seg_nb), .DIG(dig_nb), .BUSY(busy_nb), .state_dbg(st_nb)
    );

    always #5 CLK = ~CLK;

    function automatic logic [6:0] slot_code(input int v, input bit tens_slot, input bit blank);
        if (v > 99) return 7'h3F;
        if (!tens_slot) return seg_tab[v % 10];
        if (blank && (v / 10) == 0) return 7'h7F;
        return seg_tab[v / 10];
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            n = 0; disp = 0; pend = 1'b0;
            exp_dig = 2'b10; exp_seg = 7'h40; exp_seg_nb = 7'h40; exp_busy = 1'b0;
        end else begin
            sel_m      = ((n / RD) % 2) == 1;
            exp_dig    = sel_m ? 2'b01 : 2'b10;
            exp_seg    = slot_code(disp, sel_m, 1'b1);
            exp_seg_nb = slot_code(disp, sel_m, 1'b0);
            n++;
            if (n % FRAME == 0) begin
                sample = int'(VAL); load_at = n + 9; pend = 1'b1;
            end else if (pend && n == load_at) begin
                disp = sample; pend = 1'b0;
            end
            exp_busy = pend;
        end
    end

    task automatic test_reset();
        int first_dig, first_busy;
        first_dig = -1; first_busy = -1;
        RST = 1'b1; VAL = 8'd0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({dig, seg, busy} !== {2'b10, 7'h40, 1'b0})
            $display("FAIL reset_hold: dig/seg/busy=%b/%h/%b required 10/40/0", dig, seg, busy);
        else passes++;
        RST = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            checks++;
            if ({dig, seg, busy} !== {exp_dig, exp_seg, exp_busy})
                $display("FAIL reset_cycle n=%0d: %b/%h/%b required %b/%h/%b", n, dig, seg, busy, exp_dig, exp_seg, exp_busy);
            else passes++;
            if (first_dig < 0 && dig === 2'b01) first_dig = i;
            if (first_busy < 0 && busy === 1'b1) first_busy = i;
        end
        checks++;
        if (first_dig != RD + 1) $display("FAIL first_tick: DIG=01 after %0d edges, required %0d", first_dig, RD + 1);
        else passes++;
        checks++;
        if (first_busy != FRAME) $display("FAIL first_busy: BUSY rose after %0d edges, required %0d", first_busy, FRAME);
        else passes++;
    endtask

    task automatic test_display(input int v, input logic [6:0] u, input logic [6:0] t,
                                input logic [6:0] tnb, input string tag);
        int busy_cnt;
        busy_cnt = 0;
        for (int i = 0; i < FRAME + 2 && (n % FRAME) != 20; i++) begin
            @(negedge CLK);
            checks++;
            if ({dig, seg, busy, seg_nb} !== {exp_dig, exp_seg, exp_busy, exp_seg_nb})
                $display("FAIL %s_align n=%0d: %b/%h/%b/%h required %b/%h/%b/%h", tag, n, dig, seg, busy, seg_nb, exp_dig, exp_seg, exp_busy, exp_seg_nb);
            else passes++;
        end
        VAL = 8'(v);
        for (int i = 0; i < 34; i++) begin
            @(negedge CLK);
            checks++;
            if ({dig, seg, busy, seg_nb} !== {exp_dig, exp_seg, exp_busy, exp_seg_nb})
                $display("FAIL %s_cycle n=%0d: %b/%h/%b/%h required %b/%h/%b/%h", tag, n, dig, seg, busy, seg_nb, exp_dig, exp_seg, exp_busy, exp_seg_nb);
            else passes++;
            if (busy === 1'b1) busy_cnt++;
            if (n % FRAME == 11) begin
                checks++;
                if ({dig, seg, seg_nb} !== {2'b10, u, u})
                    $display("FAIL %s_units: dig/seg/seg_nb=%b/%h/%h required 10/%h/%h", tag, dig, seg, seg_nb, u, u);
                else passes++;
            end
            if (n % FRAME == 20) begin
                checks++;
                if ({dig, seg, seg_nb} !== {2'b01, t, tnb})
                    $display("FAIL %s_tens: dig/seg/seg_nb=%b/%h/%h required 01/%h/%h", tag, dig, seg, seg_nb, t, tnb);
                else passes++;
            end
        end
        checks++;
        if (busy_cnt != 9) $display("FAIL %s_busy_len: BUSY high %0d cycles, required 9", tag, busy_cnt);
        else passes++;
    endtask

    task automatic test_midframe_wrap();
        for (int i = 0; i < FRAME + 2 && (n % FRAME) != 20; i++) begin
            @(negedge CLK);
            checks++;
            if ({dig, seg, busy, seg_nb} !== {exp_dig, exp_seg, exp_busy, exp_seg_nb})
                $display("FAIL wrap_align n=%0d: %b/%h/%b/%h required %b/%h/%b/%h", n, dig, seg, busy, seg_nb, exp_dig, exp_seg, exp_busy, exp_seg_nb);
            else passes++;
        end
        VAL = 8'd19;
        for (int i = 0; i < 66; i++) begin
            @(negedge CLK);
            checks++;
            if ({dig, seg, busy, seg_nb} !== {exp_dig, exp_seg, exp_busy, exp_seg_nb})
                $display("FAIL wrap_cycle n=%0d: %b/%h/%b/%h required %b/%h/%b/%h", n, dig, seg, busy, seg_nb, exp_dig, exp_seg, exp_busy, exp_seg_nb);
            else passes++;
            if (i < 40 && n % FRAME == 5) VAL = 8'd0;
            if (i < 40 && n % FRAME == 11) begin
                checks++;
                if ({dig, seg} !== {2'b10, 7'h10}) $display("FAIL wrap_hold_units: %b/%h required 10/10", dig, seg);
                else passes++;
            end
            if (i < 40 && n % FRAME == 20) begin
                checks++;
                if ({dig, seg} !== {2'b01, 7'h79}) $display("FAIL wrap_hold_tens: %b/%h required 01/79", dig, seg);
                else passes++;
            end
            if (i >= 40 && n % FRAME == 11) begin
                checks++;
                if ({dig, seg} !== {2'b10, 7'h40}) $display("FAIL wrap_new_units: %b/%h required 10/40", dig, seg);
                else passes++;
            end
            if (i >= 40 && n % FRAME == 20) begin
                checks++;
                if ({dig, seg} !== {2'b01, 7'h7F}) $display("FAIL wrap_new_tens: %b/%h required 01/7f", dig, seg);
                else passes++;
            end
        end
    endtask

    task automatic test_reset_during_conv();
        int seen12;
        seen12 = 0;
        for (int i = 0; i < FRAME + 2 && (n % FRAME) != 20; i++) begin
            @(negedge CLK);
            checks++;
            if ({dig, seg, busy, seg_nb} !== {exp_dig, exp_seg, exp_busy, exp_seg_nb})
                $display("FAIL abort_align n=%0d: %b/%h/%b/%h required %b/%h/%b/%h", n, dig, seg, busy, seg_nb, exp_dig, exp_seg, exp_busy, exp_seg_nb);
            else passes++;
        end
        VAL = 8'd12;
        for (int i = 0; i < FRAME + 2 && (n % FRAME) != 4; i++) begin
            @(negedge CLK);
            checks++;
            if ({dig, seg, busy, seg_nb} !== {exp_dig, exp_seg, exp_busy, exp_seg_nb})
                $display("FAIL abort_pre n=%0d: %b/%h/%b/%h required %b/%h/%b/%h", n, dig, seg, busy, seg_nb, exp_dig, exp_seg, exp_busy, exp_seg_nb);
            else passes++;
        end
        checks++;
        if (busy !== 1'b1) $display("FAIL abort_in_conv: busy=%b required 1", busy);
        else passes++;
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checks++;
        if ({dig, seg, busy, dig_nb, seg_nb, busy_nb} !== {2'b10, 7'h40, 1'b0, 2'b10, 7'h40, 1'b0})
            $display("FAIL abort_reset: %b/%h/%b %b/%h/%b required 10/40/0 10/40/0", dig, seg, busy, dig_nb, seg_nb, busy_nb);
        else passes++;
        for (int i = 0; i < FRAME - 2; i++) begin
            @(negedge CLK);
            checks++;
            if ({dig, seg, busy, seg_nb} !== {exp_dig, exp_seg, exp_busy, exp_seg_nb})
                $display("FAIL abort_post n=%0d: %b/%h/%b/%h required %b/%h/%b/%h", n, dig, seg, busy, seg_nb, exp_dig, exp_seg, exp_busy, exp_seg_nb);
            else passes++;
            if (dig === 2'b10 && seg === 7'h24) seen12++;
        end
        checks++;
        if (seen12 != 0) $display("FAIL abort_no_update: units showed 2 for %0d cycles, required 0", seen12);
        else passes++;
    endtask

    task automatic test_random();
        int off;
        for (int f = 0; f < 8; f++) begin
            off = $urandom_range(1, FRAME - 1);
            for (int i = 0; i < FRAME + 2 && (n % FRAME) != off; i++) begin
                @(negedge CLK);
                checks++;
                if ({dig, seg, busy, seg_nb} !== {exp_dig, exp_seg, exp_busy, exp_seg_nb})
                    $display("FAIL rand_align n=%0d: %b/%h/%b/%h required %b/%h/%b/%h", n, dig, seg, busy, seg_nb, exp_dig, exp_seg, exp_busy, exp_seg_nb);
                else passes++;
            end
            VAL = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(100, 255)) : 8'($urandom_range(0, 99));
            for (int i = 0; i < FRAME + 12; i++) begin
                @(negedge CLK);
                checks++;
                if ({dig, seg, busy, seg_nb} !== {exp_dig, exp_seg, exp_busy, exp_seg_nb})
                    $display("FAIL rand_cycle n=%0d val=%0d: %b/%h/%b/%h required %b/%h/%b/%h", n, VAL, dig, seg, busy, seg_nb, exp_dig, exp_seg, exp_busy, exp_seg_nb);
                else passes++;
                if ($urandom_range(0, 15) == 0) VAL = 8'($urandom_range(0, 255));
            end
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_display(19,  7'h10, 7'h79, 7'h79, "val19");
        test_display(7,   7'h78, 7'h7F, 7'h40, "val7");
        test_display(150, 7'h3F, 7'h3F, 7'h3F, "val150");
        test_display(0,   7'h40, 7'h7F, 7'h40, "val0");
        test_midframe_wrap();
        test_reset_during_conv();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/count_display_driver.md
COUNT_DISPLAY_DRIVER -- requirements
Module: count_display_driver

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clock cycles per digit scan slot; the legal minimum is 16.
REQ-002 Parameter BLANK_LZ, default 1: when 1, the tens digit is blanked whenever it is zero.
REQ-003 CLK  input  1  system clock; all state SHALL update on the rising edge only.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 VAL  input  8  unsigned binary count from the upstream mod-20 up/down counter; any 0..255 value SHALL be accepted.
REQ-006 SEG  output 7  segment drive {g,f,e,d,c,b,a}, active-low.
REQ-007 DIG  output 2  digit enable, active-low; bit0 = units, bit1 = tens.
REQ-008 BUSY output 1  high while a binary-to-BCD conversion is in progress.

Function
REQ-009 Prescaler: counter 0..REFRESH_DIV-1, wrapping to 0; TICK is asserted for the one cycle in which the counter equals REFRESH_DIV-1.
REQ-010 Scan select SEL toggles on every TICK.
- SEL=0: DIG=2'b10, SEG shows the units digit.
- SEL=1: DIG=2'b01, SEG shows the tens digit.
- DIG SHALL never equal 2'b00.
REQ-011 A frame start is a TICK at which SEL changes from 1 to 0.
REQ-012 Conversion FSM has three states: IDLE, CONV and LOAD.
- IDLE -> CONV on a frame start.
- At that edge: capture VAL into the shift register; capture the flag OOR = (VAL > 99).
REQ-013 CONV lasts exactly 8 cycles, performing one shift-add-3 double-dabble iteration per cycle; CONV -> LOAD after the 8th cycle.
REQ-014 LOAD lasts 1 cycle; it writes the display registers TENS, UNITS and DOOR, then returns to IDLE.
- Latency: display registers change 9 cycles after the frame-start edge that sampled VAL.
REQ-015 BUSY = 1 in CONV and LOAD, 0 in IDLE.
REQ-016 VAL is ignored at all times except the frame-start sampling edge; mid-frame changes SHALL NOT alter the display until the next frame start.
REQ-017 Segment codes (hex, active-low):
- Digits 0-9: 40, 79, 24, 30, 19, 12, 02, 78, 00, 10.
- Blank: 7F.
- Dash (g only): 3F.
REQ-018 When DOOR=1, both digit slots SHALL show dash 3F, regardless of BCD content.
REQ-019 When DOOR=0, BLANK_LZ=1 and TENS=0, the tens slot SHALL show blank 7F; the units slot SHALL always show its digit (value 0 shows 40).
REQ-020 SEG and DIG are registered, so they change one cycle after SEL or the display registers change.
REQ-021 Frame period is 2*REFRESH_DIV cycles. Conversion (9 cycles) completes within the units slot because REFRESH_DIV >= 16.

Reset
REQ-022 While RST=1 the block SHALL hold the following values:
- Prescaler = 0, SEL = 0, FSM = IDLE.
- TENS = 0, UNITS = 0, DOOR = 0.
REQ-023 Output values on the cycle after any reset edge: DIG=2'b10, SEG=7'h40, BUSY=0.
REQ-024 Reset asserted during CONV or LOAD SHALL abort the conversion with no display update; the first sampling of VAL after reset occurs at the first frame start, 2*REFRESH_DIV cycles after release.
REQ-025 RST has priority over TICK, frame start and LOAD occurring in the same cycle.

Verification (REFRESH_DIV=16)
REQ-026 RST high 3 cycles, then low -> DIG=10, SEG=40, BUSY=0; first TICK is 16 cycles after release; first BUSY rise is 32 cycles after release.
REQ-027 VAL=19 at frame start -> BUSY high 9 cycles; then units slot SEG=10; next slot DIG=01 with SEG=79.
REQ-028 VAL=7 -> units SEG=78; tens SEG=7F with BLANK_LZ=1, or SEG=40 with BLANK_LZ=0.
REQ-029 VAL=150 -> both slots SEG=3F. A following frame with VAL=0 -> units SEG=40, tens SEG=7F.
REQ-030 Upstream wrap 19->0 driven mid-frame -> display stays 19 until the next frame start, then shows units 40 and tens blank.
REQ-031 RST pulsed 1 cycle during CONV (VAL=12) -> BUSY=0 next cycle, SEG=40, DIG=10, and no display update to 12.
